nap_countdown: RTL and testbench
================================

NAP_COUNTDOWN -- requirements
Module: nap_countdown

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports hour_ten_in, hour_one_in, min_ten_in, min_one_in, sec_ten_in, sec_one_in, each input, 4, BCD digit of the set nap duration from the time-setting block.
REQ-004 SHALL have port completeSetting, input, 1, level from the setting block, high while its setting is complete.
REQ-005 SHALL have port tick, input, 1, single-cycle 1 Hz enable.
REQ-006 SHALL have port stop, input, 1, single-cycle cancel/acknowledge key.
REQ-007 SHALL have ports hour_ten_out, hour_one_out, min_ten_out, min_one_out, sec_ten_out, sec_one_out, each output, 4, remaining time in BCD.
REQ-008 SHALL have ports running, alarm, load_err, each output, 1: counting active, alarm active, one-cycle invalid-setting pulse.

Function
REQ-009 SHALL implement FSM states IDLE, LOAD, RUN, ALARM.
REQ-010 SHALL detect the rising edge of completeSetting with a registered copy; a held level SHALL NOT re-trigger.
REQ-011 IDLE -> LOAD on completeSetting rising edge; otherwise stay IDLE.
REQ-012 LOAD SHALL last exactly one cycle and validate the digits: every digit <= 9, min_ten <= 5, sec_ten <= 5, hour_ten <= 2, and hour_ten == 2 implies hour_one <= 3.
REQ-013 On invalid digits, LOAD SHALL pulse load_err for one cycle, leave the output digits unchanged, and return to IDLE.
REQ-014 On valid nonzero digits, LOAD SHALL copy all six digits to the outputs and go to RUN; running goes high the cycle after LOAD.
REQ-015 On valid all-zero digits, LOAD SHALL go directly to ALARM.
REQ-016 In RUN, each tick SHALL decrement the six-digit BCD value by one second.
REQ-017 Decrement borrow rules: sec_one 0 -> 9 with borrow; sec_ten 0 -> 5 with borrow; min_one 0 -> 9; min_ten 0 -> 5; hour_one 0 -> 9; hour_ten 0 with borrow does not occur.
REQ-018 A tick that makes the value 00:00:00 SHALL move the FSM to ALARM on the same edge; alarm is high the following cycle.
REQ-019 stop in RUN SHALL clear all digits to 0 and go to IDLE, with no alarm.
REQ-020 In ALARM, alarm SHALL stay high until stop; stop SHALL return to IDLE with digits at 0.
REQ-021 A completeSetting rising edge in RUN or ALARM SHALL be ignored.
REQ-022 If stop and tick coincide in RUN, stop SHALL win.
REQ-023 running SHALL be high only in RUN; alarm SHALL be high only in ALARM.

Reset
REQ-024 rst low SHALL force IDLE, all digit outputs 0, running 0, alarm 0, load_err 0, and the edge-detect register 0, regardless of clk.
REQ-025 Reset asserted mid-RUN or mid-ALARM SHALL abort with no residual alarm after release.

Structure
REQ-026 The state encoding (IDLE=0, LOAD=1, RUN=2, ALARM=3) and the BCD limits (9, 5, 2, 3) SHALL reside in a shared package used with the time-setting block.
REQ-027 The BCD decrementer SHALL be a sub-module bcd_down_counter with inputs en, load, load value and outputs value, is_zero, borrow chain internal.

Verification
REQ-028 Load 00:00:03, then 3 ticks -> outputs 00:00:02, 00:00:01, 00:00:00; alarm high after the third tick; stop -> IDLE, alarm 0.
REQ-029 Load 01:00:00, then 1 tick -> 00:59:59, running stays 1.
REQ-030 Load 24:00:00, or min_ten=6 -> load_err one-cycle pulse, outputs unchanged, running 0.
REQ-031 Load 00:00:00 -> alarm high within 2 cycles of the completeSetting edge, running never 1.
REQ-032 In RUN at 00:10:00, drive stop and tick in the same cycle -> IDLE, digits 0, alarm never 1; completeSetting held high afterwards causes no reload.
REQ-033 Drive rst low during ALARM -> alarm 0 and digits 0 immediately (asynchronous); after release the block stays in IDLE.

Source files
------------

// File: rtl/nap_countdown_pkg.sv
// Shared definitions for the nap countdown and the time-setting block.
// Holds the FSM state encoding, the BCD digit limits, the six-digit time
// type and a helper that checks a time value against those limits.
package nap_countdown_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StRun   = 2'd2,
        StAlarm = 2'd3
    } nap_state_e;

    localparam logic [3:0] BcdMaxDigit   = 4'd9;
    localparam logic [3:0] BcdMaxTen     = 4'd5;
    localparam logic [3:0] BcdMaxHourTen = 4'd2;
    localparam logic [3:0] BcdMaxHourOne = 4'd3;  // hour_one limit when hour_ten is 2

    localparam int unsigned NumDigits = 6;

    // Digit positions inside bcd_time_t, least significant first.
    localparam int unsigned DigSecOne  = 0;
    localparam int unsigned DigSecTen  = 1;
    localparam int unsigned DigMinOne  = 2;
    localparam int unsigned DigMinTen  = 3;
    localparam int unsigned DigHourOne = 4;
    localparam int unsigned DigHourTen = 5;

    typedef logic [NumDigits-1:0][3:0] bcd_time_t;

    function automatic logic bcd_time_valid(input bcd_time_t t);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < NumDigits; i++) begin
            if (t[i] > BcdMaxDigit) ok = 1'b0;
        end
        if (t[DigSecTen] > BcdMaxTen) ok = 1'b0;
        if (t[DigMinTen] > BcdMaxTen) ok = 1'b0;
        if (t[DigHourTen] > BcdMaxHourTen) ok = 1'b0;
        if ((t[DigHourTen] == BcdMaxHourTen) && (t[DigHourOne] > BcdMaxHourOne)) ok = 1'b0;
        return ok;
    endfunction

    // Value a digit takes when it borrows from the next digit up.
    function automatic logic [3:0] digit_wrap(input int unsigned idx);
        logic [3:0] w;
        w = BcdMaxDigit;
        if ((idx == DigSecTen) || (idx == DigMinTen)) w = BcdMaxTen;
        // hour_ten never borrows while counting down a nonzero value
        if (idx == DigHourTen) w = 4'd0;
        return w;
    endfunction

endpackage

// File: rtl/nap_countdown_bcd_down_counter.sv
// Six-digit BCD hh:mm:ss down counter.
// Ports:
//   clk, rst    - clock, asynchronous active-low reset (value clears to 0)
//   en          - decrement by one second this cycle
//   load        - take load_value this cycle (wins over en)
//   load_value  - value to load
//   value       - current count
//   is_zero     - count is 00:00:00
module bcd_down_counter
    import nap_countdown_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      en,
    input  logic      load,
    input  bcd_time_t load_value,
    output bcd_time_t value,
    output logic      is_zero
);

    bcd_time_t            value_q, value_d;
    logic [NumDigits-1:0] borrow;

    // borrow[i]: digit i must decrement this cycle
    always_comb begin
        borrow    = '0;
        borrow[0] = en;
        for (int i = 1; i < NumDigits; i++) begin
            borrow[i] = borrow[i-1] && (value_q[i-1] == 4'd0);
        end
    end

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = load_value;
        end else begin
            for (int i = 0; i < NumDigits; i++) begin
                if (borrow[i]) begin
                    value_d[i] = (value_q[i] == 4'd0) ? digit_wrap(i) : value_q[i] - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value   = value_q;
    assign is_zero = (value_q == '0);

endmodule

// File: rtl/nap_countdown.sv
// Nap countdown timer. Loads a BCD hh:mm:ss duration on the rising edge of
// completeSetting, counts it down on each 1 Hz tick and raises alarm at zero.
// Ports:
//   clk, rst            - clock, asynchronous active-low reset
//   *_in                - set duration digits from the time-setting block
//   completeSetting     - setting-complete level; its rising edge starts a load
//   tick                - single-cycle 1 Hz enable
//   stop                - single-cycle cancel / alarm acknowledge
//   *_out               - remaining time digits
//   running, alarm      - high in RUN / ALARM respectively
//   load_err            - one-cycle pulse when the set duration is invalid
module nap_countdown
    import nap_countdown_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hour_ten_in,
    input  logic [3:0] hour_one_in,
    input  logic [3:0] min_ten_in,
    input  logic [3:0] min_one_in,
    input  logic [3:0] sec_ten_in,
    input  logic [3:0] sec_one_in,
    input  logic       completeSetting,
    input  logic       tick,
    input  logic       stop,
    output logic [3:0] hour_ten_out,
    output logic [3:0] hour_one_out,
    output logic [3:0] min_ten_out,
    output logic [3:0] min_one_out,
    output logic [3:0] sec_ten_out,
    output logic [3:0] sec_one_out,
    output logic       running,
    output logic       alarm,
    output logic       load_err
);

    localparam bcd_time_t OneSecond = bcd_time_t'(24'h00_00_01);

    nap_state_e state_q, state_d;
    logic       setting_q;
    logic       set_rise;
    bcd_time_t  set_value;
    logic       set_valid;
    logic       set_zero;
    logic       cnt_en;
    logic       cnt_load;
    bcd_time_t  cnt_load_value;
    bcd_time_t  cnt_value;
    logic       cnt_is_zero;
    logic       last_second;

    assign set_value[DigHourTen] = hour_ten_in;
    assign set_value[DigHourOne] = hour_one_in;
    assign set_value[DigMinTen]  = min_ten_in;
    assign set_value[DigMinOne]  = min_one_in;
    assign set_value[DigSecTen]  = sec_ten_in;
    assign set_value[DigSecOne]  = sec_one_in;

    assign set_rise    = completeSetting && !setting_q;
    assign set_valid   = bcd_time_valid(set_value);
    assign set_zero    = (set_value == '0);
    assign last_second = (cnt_value == OneSecond);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            setting_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            setting_q <= completeSetting;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (set_rise) state_d = StLoad;
            end
            StLoad: begin
                if (!set_valid)    state_d = StIdle;
                else if (set_zero) state_d = StAlarm;
                else               state_d = StRun;
            end
            StRun: begin
                // stop outranks a coincident tick
                if (stop)                      state_d = StIdle;
                else if (tick && last_second)  state_d = StAlarm;
                else if (cnt_is_zero)          state_d = StAlarm;
            end
            StAlarm: begin
                if (stop) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        running        = (state_q == StRun);
        alarm          = (state_q == StAlarm);
        load_err       = (state_q == StLoad) && !set_valid;
        cnt_en         = (state_q == StRun) && tick && !stop;
        // Clearing the digits on stop reuses the load path with a zero value.
        cnt_load       = ((state_q == StLoad) && set_valid) ||
                         (((state_q == StRun) || (state_q == StAlarm)) && stop);
        cnt_load_value = (state_q == StLoad) ? set_value : '0;
    end

    bcd_down_counter u_counter (
        .clk        (clk),
        .rst        (rst),
        .en         (cnt_en),
        .load       (cnt_load),
        .load_value (cnt_load_value),
        .value      (cnt_value),
        .is_zero    (cnt_is_zero)
    );

    assign hour_ten_out = cnt_value[DigHourTen];
    assign hour_one_out = cnt_value[DigHourOne];
    assign min_ten_out  = cnt_value[DigMinTen];
    assign min_one_out  = cnt_value[DigMinOne];
    assign sec_ten_out  = cnt_value[DigSecTen];
    assign sec_one_out  = cnt_value[DigSecOne];

endmodule

// File: tb/tb_nap_countdown.sv
module tb_nap_countdown;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] hour_ten_in, hour_one_in, min_ten_in, min_one_in, sec_ten_in, sec_one_in;
    logic       completeSetting, tick, stop;
    logic [3:0] hour_ten_out, hour_one_out, min_ten_out, min_one_out, sec_ten_out, sec_one_out;
    logic       running, alarm, load_err;

    nap_countdown dut (
        .clk             (clk),
        .rst             (rst),
        .hour_ten_in     (hour_ten_in),
        .hour_one_in     (hour_one_in),
        .min_ten_in      (min_ten_in),
        .min_one_in      (min_one_in),
        .sec_ten_in      (sec_ten_in),
        .sec_one_in      (sec_one_in),
        .completeSetting (completeSetting),
        .tick            (tick),
        .stop            (stop),
        .hour_ten_out    (hour_ten_out),
        .hour_one_out    (hour_one_out),
        .min_ten_out     (min_ten_out),
        .min_one_out     (min_one_out),
        .sec_ten_out     (sec_ten_out),
        .sec_one_out     (sec_one_out),
        .running         (running),
        .alarm           (alarm),
        .load_err        (load_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] digits;
        logic        running;
        logic        alarm;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          model_sec;
    logic [23:0] got;

    assign got = {hour_ten_out, hour_one_out, min_ten_out, min_one_out, sec_ten_out, sec_one_out};

    function automatic logic [23:0] to_bcd(input int s);
        int h, m, x;
        h = s / 3600;
        m = (s / 60) % 60;
        x = s % 60;
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
    endfunction

    function automatic int to_sec(input logic [23:0] b);
        int h, m, x;
        h = int'(b[23:20]) * 10 + int'(b[19:16]);
        m = int'(b[15:12]) * 10 + int'(b[11:8]);
        x = int'(b[7:4]) * 10 + int'(b[3:0]);
        return h * 3600 + m * 60 + x;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_digits(input logic [23:0] b);
        {hour_ten_in, hour_one_in, min_ten_in, min_one_in, sec_ten_in, sec_one_in} = b;
    endtask

    // Edge of completeSetting, one LOAD cycle, then RUN/ALARM/IDLE.
    task automatic do_load(input logic [23:0] b, input bit keep_high);
        set_digits(b);
        completeSetting = 1'b1;
        step();
        step();
        if (!keep_high) completeSetting = 1'b0;
        model_sec = to_sec(b);
    endtask

    // Model one tick: push the expectation, drive the tick.
    task automatic tick_with_expect();
        exp_t e;
        model_sec  = model_sec - 1;
        e.digits   = to_bcd(model_sec);
        e.running  = (model_sec != 0);
        e.alarm    = (model_sec == 0);
        sb.push_back(e);
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++;
        if (got !== 24'h0) begin
            errors++; $display("FAIL reset_digits: got %h expected 000000", got);
        end
        checks++;
        if ({running, alarm, load_err} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b expected 000", {running, alarm, load_err});
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_countdown_3s();
        exp_t        e;
        logic [23:0] held;
        do_load(24'h00_00_03, 1'b0);
        checks++;
        if (got !== 24'h00_00_03 || running !== 1'b1) begin
            errors++; $display("FAIL load_3s: got %h run %b expected 000003 run 1", got, running);
        end
        for (int i = 0; i < 3; i++) begin
            tick_with_expect();
            e = sb.pop_front();
            checks++;
            if (got !== e.digits || running !== e.running || alarm !== e.alarm) begin
                errors++;
                $display("FAIL countdown_tick%0d: got %h run %b alm %b expected %h run %b alm %b",
                         i, got, running, alarm, e.digits, e.running, e.alarm);
            end
            held = got;
            step();
            checks++;
            if (got !== e.digits) begin
                errors++; $display("FAIL no_tick_hold%0d: got %h expected %h", i, got, held);
            end
        end
        pulse_stop();
        checks++;
        if (got !== 24'h0 || alarm !== 1'b0 || running !== 1'b0) begin
            errors++;
            $display("FAIL alarm_stop: got %h run %b alm %b expected 000000 run 0 alm 0",
                     got, running, alarm);
        end
    endtask

    task automatic test_borrow(input logic [23:0] start);
        exp_t e;
        do_load(start, 1'b0);
        tick_with_expect();
        e = sb.pop_front();
        checks++;
        if (got !== e.digits || running !== 1'b1 || alarm !== 1'b0) begin
            errors++;
            $display("FAIL borrow_from_%h: got %h run %b alm %b expected %h run 1 alm 0",
                     start, got, running, alarm, e.digits);
        end
        pulse_stop();
    endtask

    task automatic test_load_err();
        logic [23:0] bad [4];
        bad[0] = 24'h24_00_00;
        bad[1] = 24'h00_60_00;
        bad[2] = 24'h00_00_60;
        bad[3] = 24'h00_00_0a;
        for (int i = 0; i < 4; i++) begin
            set_digits(bad[i]);
            completeSetting = 1'b1;
            step();
            checks++;
            if (load_err !== 1'b1) begin
                errors++; $display("FAIL load_err_pulse_%h: got %b expected 1", bad[i], load_err);
            end
            step();
            checks++;
            if (load_err !== 1'b0 || running !== 1'b0 || alarm !== 1'b0 || got !== 24'h0) begin
                errors++;
                $display("FAIL load_err_after_%h: err %b run %b alm %b dig %h expected 0 0 0 0",
                         bad[i], load_err, running, alarm, got);
            end
            completeSetting = 1'b0;
            step();
        end
    endtask

    task automatic test_zero_load();
        set_digits(24'h0);
        completeSetting = 1'b1;
        step();
        checks++;
        if (alarm !== 1'b0 || running !== 1'b0 || load_err !== 1'b0) begin
            errors++; $display("FAIL zero_load_cycle: alm %b run %b err %b expected 0 0 0",
                               alarm, running, load_err);
        end
        step();
        checks++;
        if (alarm !== 1'b1 || running !== 1'b0) begin
            errors++; $display("FAIL zero_load_alarm: alm %b run %b expected 1 0", alarm, running);
        end
        completeSetting = 1'b0;
        step();
        checks++;
        if (alarm !== 1'b1) begin
            errors++; $display("FAIL zero_alarm_held: got %b expected 1", alarm);
        end
        pulse_stop();
        checks++;
        if (alarm !== 1'b0) begin
            errors++; $display("FAIL zero_alarm_stop: got %b expected 0", alarm);
        end
    endtask

    task automatic test_stop_tick();
        do_load(24'h00_10_00, 1'b1);
        checks++;
        if (running !== 1'b1 || got !== 24'h00_10_00) begin
            errors++; $display("FAIL load_10m: got %h run %b expected 001000 run 1", got, running);
        end
        stop = 1'b1;
        tick = 1'b1;
        step();
        stop = 1'b0;
        tick = 1'b0;
        checks++;
        if (got !== 24'h0 || running !== 1'b0 || alarm !== 1'b0) begin
            errors++; $display("FAIL stop_tick: got %h run %b alm %b expected 000000 0 0",
                               got, running, alarm);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (running !== 1'b0 || alarm !== 1'b0 || got !== 24'h0) begin
                errors++; $display("FAIL held_no_reload%0d: got %h run %b alm %b expected 0 0 0",
                                   i, got, running, alarm);
            end
        end
        completeSetting = 1'b0;
        step();
    endtask

    task automatic test_ignore_in_run();
        exp_t e;
        do_load(24'h00_00_05, 1'b0);
        set_digits(24'h00_00_30);
        completeSetting = 1'b1;
        step();
        step();
        completeSetting = 1'b0;
        checks++;
        if (got !== 24'h00_00_05 || running !== 1'b1) begin
            errors++; $display("FAIL ignore_reload: got %h run %b expected 000005 run 1",
                               got, running);
        end
        tick_with_expect();
        e = sb.pop_front();
        checks++;
        if (got !== e.digits) begin
            errors++; $display("FAIL ignore_then_tick: got %h expected %h", got, e.digits);
        end
        pulse_stop();
    endtask

    task automatic test_reset_mid();
        // mid-RUN
        do_load(24'h00_00_09, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (got !== 24'h0 || running !== 1'b0) begin
            errors++; $display("FAIL reset_mid_run: got %h run %b expected 000000 0", got, running);
        end
        #2;
        rst = 1'b1;
        step();
        // mid-ALARM
        do_load(24'h00_00_01, 1'b0);
        tick = 1'b1;
        step();
        tick = 1'b0;
        checks++;
        if (alarm !== 1'b1) begin
            errors++; $display("FAIL alarm_before_reset: got %b expected 1", alarm);
        end
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if (alarm !== 1'b0 || got !== 24'h0) begin
            errors++; $display("FAIL reset_mid_alarm: alm %b dig %h expected 0 000000", alarm, got);
        end
        #2;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (alarm !== 1'b0 || running !== 1'b0 || got !== 24'h0) begin
            errors++; $display("FAIL after_reset_idle: alm %b run %b dig %h expected 0 0 000000",
                               alarm, running, got);
        end
    endtask

    initial begin
        rst             = 1'b0;
        completeSetting = 1'b0;
        tick            = 1'b0;
        stop            = 1'b0;
        set_digits(24'h0);
        test_reset();
        test_countdown_3s();
        test_borrow(24'h01_00_00);
        test_borrow(24'h23_59_59);
        test_borrow(24'h10_00_00);
        test_load_err();
        test_zero_load();
        test_stop_tick();
        test_ignore_in_run();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
